mem_arbiter: RTL and testbench

- Shares the single byte-wide, single-port instruction/data memory between two requesters.
- Requester 0 is the multicycle CPU controller/datapath port (instruction fetch bytes, LB/SB).
- Requester 1 is the debug/program-loader port.
- Uses a per-requester req/ack handshake, registered memory-side outputs and a configurable memory read latency, so the controller can stall on ack instead of assuming one-cycle memory.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter_arb2_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and its picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // Wait counter is 3 bits wide, so the read latency tops out at 7.
  localparam int unsigned LAT_MAX = 7;

  function automatic bit lat_ok(input int unsigned lat);
    return (lat != 0) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the two-way memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  // Requesters plus memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );

endinterface

// File: rtl/mem_arbiter_arb2_pick.sv
// Combinational two-way picker: single requester wins outright; on a tie
// either round-robin against the last owner or fixed priority to req0.
module arb2_pick #(
  parameter bit FAIR = 1'b1
) (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_idx
);

  // Grant selection.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = 1'b0;
    if (req0 && req1) begin
      gnt_idx = FAIR ? ~last : 1'b0;
    end else if (req1) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port byte memory between the CPU (0) and the
// debug/loader port (1) with req/ack handshakes and MEM_LAT read latency.
module mem_arbiter #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned FAIR    = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  import mem_arb_pkg::*;

  if (!lat_ok(MEM_LAT)) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT=%0d outside legal range 1..7", MEM_LAT);
  end

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT);

  arb_state_t    state;
  logic [2:0]    cnt;
  logic          gnt_valid;
  logic          gnt_idx;
  logic          we_sel;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

  arb2_pick #(
    .FAIR(FAIR != 0)
  ) u_pick (
    .req0      (bus.cpu_req),
    .req1      (bus.dbg_req),
    .last      (bus.owner),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Route the winning requester's command toward the memory registers.
  always_comb begin
    we_sel    = bus.cpu_we;
    addr_sel  = bus.cpu_addr;
    wdata_sel = bus.cpu_wdata;
    if (gnt_idx == OWN_DBG) begin
      we_sel    = bus.dbg_we;
      addr_sel  = bus.dbg_addr;
      wdata_sel = bus.dbg_wdata;
    end
  end

  // Access sequencer: IDLE -> ISSUE -> WAIT x MEM_LAT -> ACK, registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.dbg_ack   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.owner     <= OWN_DBG;
    end else begin
      bus.mem_en  <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            bus.owner     <= gnt_idx;
            bus.mem_we    <= we_sel;
            bus.mem_addr  <= addr_sel;
            bus.mem_wdata <= wdata_sel;
            bus.mem_en    <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (!bus.mem_we) begin
              if (bus.owner == OWN_DBG) bus.dbg_rdata <= bus.mem_rdata;
              else                      bus.cpu_rdata <= bus.mem_rdata;
            end
            if (bus.owner == OWN_DBG) bus.dbg_ack <= 1'b1;
            else                      bus.cpu_ack <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: u1 runs MEM_LAT=1/FAIR=1, u3 runs
// MEM_LAT=3/FAIR=0. Each has a memory model whose read data is valid only
// in the exact cycle MEM_LAT after mem_en.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.AW(8), .DW(8)) b1 ();
  mem_arbiter_if #(.AW(8), .DW(8)) b3 ();

  mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .FAIR(1)) u1 (.clk(clk), .rst(rst1), .bus(b1.slave));
  mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(3), .FAIR(0)) u3 (.clk(clk), .rst(rst3), .bus(b3.slave));

  // Memory models with a preload port.
  logic [7:0] mem1 [256] = '{default: 8'h00};
  logic [7:0] mem3 [256] = '{default: 8'h00};
  logic [2:0] m1_cnt = '0, m3_cnt = '0;
  logic [7:0] m1_a = '0, m3_a = '0;
  logic       ld1 = 1'b0, ld3 = 1'b0;
  logic [7:0] ld_a = '0, ld_d = '0;

  always @(posedge clk) begin
    if (ld1) mem1[ld_a] <= ld_d;
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
    if (b1.mem_en) begin m1_cnt <= 3'd1; m1_a <= b1.mem_addr; end
    else if (m1_cnt != 0) m1_cnt <= m1_cnt - 3'd1;
  end
  always @(posedge clk) begin
    if (ld3) mem3[ld_a] <= ld_d;
    if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
    if (b3.mem_en) begin m3_cnt <= 3'd3; m3_a <= b3.mem_addr; end
    else if (m3_cnt != 0) m3_cnt <= m3_cnt - 3'd1;
  end
  assign b1.mem_rdata = (m1_cnt == 3'd1) ? mem1[m1_a] : 8'hEE;
  assign b3.mem_rdata = (m3_cnt == 3'd1) ? mem3[m3_a] : 8'hEE;

  typedef struct packed {
    logic       busy, mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic       cpu_ack, dbg_ack, owner;
    logic [7:0] cpu_rdata, dbg_rdata;
  } snap_t;

  typedef struct {
    int         en_cyc, en_cnt, ack_cyc, other_ack, busy_cnt, unstable;
    logic       we;
    logic [7:0] addr, wdata;
  } acc_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic snap_t snap(input int inst);
    snap_t s;
    if (inst == 1) s = '{b1.busy, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata,
                         b1.cpu_ack, b1.dbg_ack, b1.owner, b1.cpu_rdata, b1.dbg_rdata};
    else           s = '{b3.busy, b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata,
                         b3.cpu_ack, b3.dbg_ack, b3.owner, b3.cpu_rdata, b3.dbg_rdata};
    return s;
  endfunction

  task automatic drive(input int inst, input bit who, input logic req, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (inst == 1) begin
      if (!who) begin b1.cpu_req = req; b1.cpu_we = we; b1.cpu_addr = addr; b1.cpu_wdata = wdata; end
      else      begin b1.dbg_req = req; b1.dbg_we = we; b1.dbg_addr = addr; b1.dbg_wdata = wdata; end
    end else begin
      if (!who) begin b3.cpu_req = req; b3.cpu_we = we; b3.cpu_addr = addr; b3.cpu_wdata = wdata; end
      else      begin b3.dbg_req = req; b3.dbg_we = we; b3.dbg_addr = addr; b3.dbg_wdata = wdata; end
    end
  endtask

  task automatic load(input int inst, input logic [7:0] a, input logic [7:0] d);
    ld_a = a; ld_d = d;
    if (inst == 1) ld1 = 1'b1; else ld3 = 1'b1;
    tick();
    ld1 = 1'b0; ld3 = 1'b0;
  endtask

  // One access from the current IDLE cycle (cycle 0); req drops when ack is seen.
  // Optionally changes the request address at cycle chg_cyc.
  task automatic access(input int inst, input bit who, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input int ncyc, input int chg_cyc,
                        input logic [7:0] chg_addr, output acc_t r);
    snap_t s;
    logic [7:0] cur_addr;
    r.en_cyc = -1; r.en_cnt = 0; r.ack_cyc = -1; r.other_ack = 0; r.busy_cnt = 0;
    r.unstable = 0; r.we = 1'b0; r.addr = '0; r.wdata = '0;
    cur_addr = addr;
    drive(inst, who, 1'b1, we, cur_addr, wdata);
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      s = snap(inst);
      if (c == chg_cyc) begin
        cur_addr = chg_addr;
        drive(inst, who, (r.ack_cyc < 0), we, cur_addr, wdata);
      end
      if (s.busy) r.busy_cnt++;
      if (r.en_cyc >= 0 && {s.mem_we, s.mem_addr, s.mem_wdata} != {r.we, r.addr, r.wdata}) r.unstable++;
      if (s.mem_en) begin
        r.en_cnt++;
        if (r.en_cyc < 0) begin r.en_cyc = c; r.we = s.mem_we; r.addr = s.mem_addr; r.wdata = s.mem_wdata; end
      end
      if (who ? s.cpu_ack : s.dbg_ack) r.other_ack++;
      if ((who ? s.dbg_ack : s.cpu_ack) && r.ack_cyc < 0) begin
        r.ack_cyc = c;
        drive(inst, who, 1'b0, we, cur_addr, wdata);
      end
    end
    drive(inst, who, 1'b0, we, cur_addr, wdata);
  endtask

  task automatic test_reset();
    snap_t s;
    s = snap(1);
    checks++; if ({s.busy, s.mem_en, s.mem_we, s.cpu_ack, s.dbg_ack, s.owner} !== 6'b000001) begin
      errors++; $display("FAIL reset_ctrl_u1: got %b want 000001", {s.busy, s.mem_en, s.mem_we, s.cpu_ack, s.dbg_ack, s.owner}); end
    checks++; if ({s.mem_addr, s.mem_wdata, s.cpu_rdata, s.dbg_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_data_u1: got %h want 0", {s.mem_addr, s.mem_wdata, s.cpu_rdata, s.dbg_rdata}); end
    s = snap(3);
    checks++; if ({s.busy, s.mem_en, s.mem_we, s.cpu_ack, s.dbg_ack, s.owner} !== 6'b000001) begin
      errors++; $display("FAIL reset_ctrl_u3: got %b want 000001", {s.busy, s.mem_en, s.mem_we, s.cpu_ack, s.dbg_ack, s.owner}); end
    checks++; if ({s.mem_addr, s.mem_wdata, s.cpu_rdata, s.dbg_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_data_u3: got %h want 0", {s.mem_addr, s.mem_wdata, s.cpu_rdata, s.dbg_rdata}); end
    rst1 = 1'b0; rst3 = 1'b0;
    tick(); tick();
    checks++; if ({b1.busy, b1.mem_en, b3.busy, b3.mem_en} !== 4'b0000) begin
      errors++; $display("FAIL idle_no_req: got %b want 0000", {b1.busy, b1.mem_en, b3.busy, b3.mem_en}); end
  endtask

  task automatic test_dbg_read_lat1();
    acc_t r;
    access(1, 1'b1, 1'b0, 8'h30, 8'h00, 6, -1, 8'h00, r);
    checks++; if (r.ack_cyc !== 3) begin errors++; $display("FAIL dbg_rd1_ack_cycle: got %0d want 3", r.ack_cyc); end
    checks++; if (b1.dbg_rdata !== 8'h5A) begin errors++; $display("FAIL dbg_rd1_data: got %h want 5a", b1.dbg_rdata); end
    checks++; if (b1.owner !== 1'b1) begin errors++; $display("FAIL dbg_rd1_owner: got %b want 1", b1.owner); end
  endtask

  task automatic test_cpu_read();
    acc_t r;
    access(1, 1'b0, 1'b0, 8'h10, 8'h00, 6, -1, 8'h00, r);
    checks++; if (r.en_cyc !== 1 || r.en_cnt !== 1) begin
      errors++; $display("FAIL cpu_rd_mem_en: got cycle %0d count %0d want cycle 1 count 1", r.en_cyc, r.en_cnt); end
    checks++; if (r.addr !== 8'h10 || r.we !== 1'b0) begin
      errors++; $display("FAIL cpu_rd_mem_addr: got %h we %b want 10 we 0", r.addr, r.we); end
    checks++; if (r.ack_cyc !== 3 || r.other_ack !== 0) begin
      errors++; $display("FAIL cpu_rd_ack: got cycle %0d other %0d want cycle 3 other 0", r.ack_cyc, r.other_ack); end
    checks++; if (r.busy_cnt !== 3) begin errors++; $display("FAIL cpu_rd_busy: got %0d cycles want 3", r.busy_cnt); end
    checks++; if (b1.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL cpu_rd_data: got %h want a5", b1.cpu_rdata); end
    checks++; if (b1.dbg_rdata !== 8'h5A) begin errors++; $display("FAIL cpu_rd_dbg_kept: got %h want 5a", b1.dbg_rdata); end
  endtask

  task automatic test_addr_change();
    acc_t r;
    load(1, 8'h10, 8'h6B);
    access(1, 1'b0, 1'b0, 8'h10, 8'h00, 6, 1, 8'h11, r);
    checks++; if (r.addr !== 8'h10 || r.unstable !== 0) begin
      errors++; $display("FAIL addr_chg_mem_addr: got %h unstable %0d want 10 unstable 0", r.addr, r.unstable); end
    checks++; if (b1.cpu_rdata !== 8'h6B) begin errors++; $display("FAIL addr_chg_data: got %h want 6b", b1.cpu_rdata); end
  endtask

  task automatic test_dbg_read_lat3();
    acc_t r;
    access(3, 1'b1, 1'b0, 8'h40, 8'h00, 8, -1, 8'h00, r);
    checks++; if (r.ack_cyc !== 5 || r.busy_cnt !== 5) begin
      errors++; $display("FAIL dbg_rd3_timing: got ack %0d busy %0d want ack 5 busy 5", r.ack_cyc, r.busy_cnt); end
    checks++; if (b3.dbg_rdata !== 8'hC3) begin errors++; $display("FAIL dbg_rd3_data: got %h want c3", b3.dbg_rdata); end
  endtask

  task automatic test_dbg_write();
    acc_t r;
    access(3, 1'b1, 1'b1, 8'h20, 8'h3C, 10, -1, 8'h00, r);
    checks++; if (r.en_cyc !== 1 || r.en_cnt !== 1) begin
      errors++; $display("FAIL dbg_wr_mem_en: got cycle %0d count %0d want cycle 1 count 1", r.en_cyc, r.en_cnt); end
    checks++; if ({r.we, r.addr, r.wdata} !== {1'b1, 8'h20, 8'h3C} || r.unstable !== 0) begin
      errors++; $display("FAIL dbg_wr_bus: got we %b addr %h wdata %h unstable %0d want 1 20 3c 0", r.we, r.addr, r.wdata, r.unstable); end
    checks++; if (r.ack_cyc !== 5 || r.other_ack !== 0) begin
      errors++; $display("FAIL dbg_wr_ack: got cycle %0d other %0d want cycle 5 other 0", r.ack_cyc, r.other_ack); end
    checks++; if (b3.dbg_rdata !== 8'hC3 || b3.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL dbg_wr_rdata_kept: got dbg %h cpu %h want c3 00", b3.dbg_rdata, b3.cpu_rdata); end
    checks++; if (mem3[8'h20] !== 8'h3C) begin errors++; $display("FAIL dbg_wr_mem: got %h want 3c", mem3[8'h20]); end
  endtask

  task automatic test_reset_mid();
    snap_t s;
    int en_cyc = -1, en_cnt = 0, ack_cyc = -1, early_ack = 0;
    drive(1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();                                   // cycle 1: ISSUE
    tick();                                   // cycle 2: WAIT
    checks++; if (b1.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", b1.busy); end
    rst1 = 1'b1;
    tick();                                   // cycle 3: back in IDLE
    s = snap(1);
    checks++; if ({s.busy, s.mem_en, s.cpu_ack, s.dbg_ack} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_abort: got busy/en/acks %b want 0000", {s.busy, s.mem_en, s.cpu_ack, s.dbg_ack}); end
    rst1 = 1'b0;
    for (int c = 4; c <= 10; c++) begin
      tick();
      s = snap(1);
      if (s.mem_en) begin en_cnt++; if (en_cyc < 0) en_cyc = c; end
      if (s.cpu_ack && ack_cyc < 0) begin ack_cyc = c; drive(1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00); end
      if (s.dbg_ack) early_ack++;
    end
    checks++; if (en_cyc !== 4 || en_cnt !== 1) begin
      errors++; $display("FAIL rstmid_reissue: got mem_en cycle %0d count %0d want 4 1", en_cyc, en_cnt); end
    checks++; if (ack_cyc !== 6 || early_ack !== 0) begin
      errors++; $display("FAIL rstmid_ack: got cycle %0d dbg_acks %0d want 6 0", ack_cyc, early_ack); end
    checks++; if (b1.cpu_rdata !== 8'h6B) begin errors++; $display("FAIL rstmid_data: got %h want 6b", b1.cpu_rdata); end
  endtask

  // Both requesters hold req from reset release; each drops it only in its ack cycle.
  task automatic test_tie(input int inst, input logic [3:0] want_own, input int first, input int gap);
    snap_t s;
    logic [3:0] own = '0;
    int cyc [4] = '{-1, -1, -1, -1};
    int n = 0, both = 0;
    if (inst == 1) rst1 = 1'b1; else rst3 = 1'b1;
    drive(inst, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(inst, 1'b1, 1'b1, 1'b0, 8'h30, 8'h00);
    tick();
    rst1 = 1'b0; rst3 = 1'b0;               // cycle 0
    for (int c = 1; c <= 40 && n < 4; c++) begin
      tick();
      s = snap(inst);
      drive(inst, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      drive(inst, 1'b1, 1'b1, 1'b0, 8'h30, 8'h00);
      if (s.cpu_ack && s.dbg_ack) both++;
      if (s.cpu_ack) begin own[n] = 1'b0; cyc[n] = c; n++; drive(inst, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00); end
      else if (s.dbg_ack) begin own[n] = 1'b1; cyc[n] = c; n++; drive(inst, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00); end
    end
    drive(inst, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    drive(inst, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
    tick(); tick();
    checks++; if (n !== 4 || both !== 0) begin
      errors++; $display("FAIL tie%0d_count: got %0d acks %0d double want 4 0", inst, n, both); end
    checks++; if (own !== want_own) begin
      errors++; $display("FAIL tie%0d_order: got owners(bit0 first) %b want %b", inst, own, want_own); end
    checks++; if (cyc[0] !== first || cyc[1] !== first + gap || cyc[2] !== first + 2*gap || cyc[3] !== first + 3*gap) begin
      errors++; $display("FAIL tie%0d_spacing: got %0d %0d %0d %0d want first %0d gap %0d", inst, cyc[0], cyc[1], cyc[2], cyc[3], first, gap); end
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00); drive(1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00); drive(3, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    load(1, 8'h10, 8'hA5);
    load(1, 8'h11, 8'h77);
    load(1, 8'h30, 8'h5A);
    load(3, 8'h40, 8'hC3);
    test_reset();
    test_dbg_read_lat1();
    test_cpu_read();
    test_addr_change();
    test_dbg_read_lat3();
    test_dbg_write();
    test_reset_mid();
    test_tie(1, 4'b1010, 3, 4);
    test_tie(3, 4'b0000, 5, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
